jtframe_rom_2slot: RTL and testbench
====================================

# jtframe_rom_2slot

Two-client ROM read requester sitting on the game side of the framework's SDRAM read port. It drives `sdram_req`/`sdram_addr` and consumes `sdram_ack`/`data_read`/`data_rdy`/`loop_rst` from the SDRAM controller. Each client slot keeps a one-line 32-bit cache, and requests are issued only on a cache miss. Slots are arbitrated round-robin, one outstanding transaction at a time.

## Interface
Parameters:
- `AW0`, default 17: slot 0 address width, in 16-bit words.
- `AW1`, default 17: slot 1 address width, in 16-bit words.
- `OFFSET0`, default 22'h0: slot 0 base in SDRAM word space.
- `OFFSET1`, default 22'h0: slot 1 base in SDRAM word space.

Ports:
- `clk_rom` in 1: single clock for all logic.
- `rst_n` in 1: reset, asynchronous, active-low.
- `slot0_cs` in 1: slot 0 read request, level.
- `slot0_addr` in AW0: slot 0 word address.
- `slot0_dout` out 16: slot 0 read data.
- `slot0_ok` out 1: `slot0_dout` valid for the current `slot0_addr`.
- `slot1_cs`, `slot1_addr` (AW1), `slot1_dout`, `slot1_ok`: same as slot 0, for slot 1.
- `sdram_req` out 1: read request to the controller, level.
- `sdram_addr` out 22: SDRAM word address, even-aligned.
- `sdram_ack` in 1: one-cycle pulse; the controller has taken the request.
- `data_read` in 32: line data; `[15:0]` is the even word, `[31:16]` the odd word.
- `data_rdy` in 1: one-cycle pulse; `data_read` valid.
- `loop_rst` in 1: controller re-init; synchronous abort.
- `refresh_en` out 1: high when the requester is idle with nothing pending.

## Operation
- Per-slot cache state:
  - `valid`, 1 bit.
  - `tag`, AWn-1 bits, compared against `addr[AWn-1:1]`.
  - `line`, 32 bits.
- `slotN_ok` = `cs` & `valid` & (`tag` == `addr[AWn-1:1]`). Combinational from registered cache state.
- `slotN_dout` = `addr[0]` ? `line[31:16]` : `line[15:0]`. Combinational.
- Slot pending = `cs` & ~`ok`.
- FSM with states IDLE, WAIT_ACK, WAIT_RDY.
  - IDLE: if any slot is pending, select one, latch `sel` and tag, register `sdram_req`=1, go to WAIT_ACK.
  - WAIT_ACK: on `sdram_ack`, `sdram_req`=0 at the next edge, go to WAIT_RDY.
  - WAIT_RDY: on `data_rdy`, write `line`=`data_read`, `tag`=latched tag, `valid`=1 into slot `sel`, go to IDLE.
- Arbitration:
  - If only one slot is pending, serve it.
  - If both are pending, serve the slot not served last. After reset, "last" = slot 1, so slot 0 goes first.
- Address arithmetic: `sdram_addr` = OFFSETn + zero-extended {`addr[AWn-1:1]`, 1'b0}, truncated to 22 bits (wraps modulo 2^22). Latched in IDLE; held stable until the next transaction.
- A slot address change during WAIT_ACK/WAIT_RDY does not abort the transaction. The fill uses the latched tag, `ok` stays low on mismatch, and a new miss is issued from IDLE.
- `cs` dropping mid-transaction: the transaction still completes and fills the cache.
- `sdram_ack` outside WAIT_ACK is ignored; `data_rdy` outside WAIT_RDY is ignored.
- `loop_rst`=1 (synchronous, highest priority after `rst_n`):
  - Effect at the next edge: state=IDLE, `sdram_req`=0, both `valid`=0.
  - No request is issued while `loop_rst` is high.
  - Round-robin pointer and `sdram_addr` are retained.
- `refresh_en` = (state==IDLE) & no slot pending, registered.

## Timing
- Reset values:
  - state IDLE, `sdram_req` 0, `sdram_addr` 0, `valid` 0 for both slots, `line` 0, tag 0, `refresh_en` 1.
  - Hence `slotN_ok` 0 and `slotN_dout` 0.
- Miss latency:
  - `cs`/`addr` sampled at edge E0 (IDLE) → `sdram_req` high after E0.
  - `ack` at edge Ea → `req` low after Ea.
  - `data_rdy` at edge Er → `ok` high immediately after Er.
  - With an ack-in-first-cycle controller and `data_rdy` 4 cycles after ack, `ok` rises 6 cycles after `cs`.
- Hit latency: 0 cycles. `ok` follows the `addr` change within the same cycle when the tag matches.
- Back-to-back: after the WAIT_RDY fill, IDLE can issue the next request one edge later. Minimum request spacing is 1 idle cycle.
- `sdram_req` never drops before `sdram_ack`. `sdram_addr` never changes while `sdram_req`=1 or in WAIT_RDY.
- `rst_n` asserted mid-transaction: immediate async return to reset values. A later stray `data_rdy` is ignored.

## Test plan
- Reset:
  - Stimulus: `rst_n`=0, then release with both `cs`=0.
  - Required: `sdram_req`=0, `ok`=0, `refresh_en`=1, no request ever issued.
- Slot 0 miss then hit:
  - Stimulus: OFFSET0=22'h100, `slot0_addr`=17'h00005, `data_read`=32'hBEEF_CAFE.
  - Required: `sdram_addr`=22'h104, `dout`=16'hBEEF, `ok`=1.
  - Follow-up: `addr`→17'h00004.
  - Required: `dout`=16'hCAFE, `ok` held, no new `sdram_req`.
- Simultaneous misses:
  - Stimulus: both slots miss in the same cycle.
  - Required: slot 0 served first, then slot 1. On a repeat with both missing, slot 0 again (alternation after a slot-1 win).
- Address change during WAIT_RDY:
  - Stimulus: `slot1_addr` 0→2 before `data_rdy`.
  - Required: fill tag 0, `slot1_ok` stays 0, second request issued at OFFSET1+2.
- `loop_rst` in WAIT_ACK:
  - Stimulus: pulse `loop_rst` while in WAIT_ACK.
  - Required: `req`=0 next cycle, both `ok`=0; the request is reissued after `loop_rst` drops.
- Address wrap:
  - Stimulus: OFFSET0=22'h3FFFFE, `addr`=4.
  - Required: `sdram_addr`=22'h000002.

Source files
------------

// File: rtl/jtframe_rom_2slot.sv
// Two-client SDRAM ROM read requester with a one-line 32-bit cache per slot.
// Misses are served round-robin; only one SDRAM transaction is in flight at a time.
module jtframe_rom_2slot #(
  parameter int          AW0     = 17,
  parameter int          AW1     = 17,
  parameter logic [21:0] OFFSET0 = 22'h0,
  parameter logic [21:0] OFFSET1 = 22'h0
)(
  input  logic           clk_rom,
  input  logic           rst_n,
  input  logic           slot0_cs,
  input  logic [AW0-1:0] slot0_addr,
  output logic [15:0]    slot0_dout,
  output logic           slot0_ok,
  input  logic           slot1_cs,
  input  logic [AW1-1:0] slot1_addr,
  output logic [15:0]    slot1_dout,
  output logic           slot1_ok,
  output logic           sdram_req,
  output logic [21:0]    sdram_addr,
  input  logic           sdram_ack,
  input  logic [31:0]    data_read,
  input  logic           data_rdy,
  input  logic           loop_rst,
  output logic           refresh_en
);
  localparam int TW = (AW0 > AW1 ? AW0 : AW1) - 1;

  typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_RDY} state_t;

  state_t         state;
  logic           valid0, valid1;
  logic [AW0-2:0] tag0;
  logic [AW1-2:0] tag1;
  logic [31:0]    line0, line1;
  logic [TW-1:0]  lat_tag;
  // sel doubles as the round-robin "last served" pointer
  logic           sel;
  logic           pend0, pend1, pick;
  logic [21:0]    base0, base1;

  assign slot0_ok   = slot0_cs & valid0 & (tag0 == slot0_addr[AW0-1:1]);
  assign slot1_ok   = slot1_cs & valid1 & (tag1 == slot1_addr[AW1-1:1]);
  assign slot0_dout = slot0_addr[0] ? line0[31:16] : line0[15:0];
  assign slot1_dout = slot1_addr[0] ? line1[31:16] : line1[15:0];

  assign pend0 = slot0_cs & ~slot0_ok;
  assign pend1 = slot1_cs & ~slot1_ok;
  assign pick  = pend1 & (~pend0 | ~sel);

  // Line base in SDRAM word space, wrapping modulo 2^22
  assign base0 = OFFSET0 + 22'({slot0_addr[AW0-1:1], 1'b0});
  assign base1 = OFFSET1 + 22'({slot1_addr[AW1-1:1], 1'b0});

  always_ff @(posedge clk_rom or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sdram_req  <= 1'b0;
      sdram_addr <= 22'd0;
      valid0     <= 1'b0;
      valid1     <= 1'b0;
      tag0       <= '0;
      tag1       <= '0;
      line0      <= 32'd0;
      line1      <= 32'd0;
      lat_tag    <= '0;
      sel        <= 1'b1;
      refresh_en <= 1'b1;
    end else begin
      refresh_en <= (state == IDLE) & ~(pend0 | pend1);
      if (loop_rst) begin
        state     <= IDLE;
        sdram_req <= 1'b0;
        valid0    <= 1'b0;
        valid1    <= 1'b0;
      end else begin
        case (state)
          IDLE: if (pend0 | pend1) begin
            sel        <= pick;
            lat_tag    <= pick ? TW'(slot1_addr[AW1-1:1]) : TW'(slot0_addr[AW0-1:1]);
            sdram_addr <= pick ? base1 : base0;
            sdram_req  <= 1'b1;
            state      <= WAIT_ACK;
          end
          WAIT_ACK: if (sdram_ack) begin
            sdram_req <= 1'b0;
            state     <= WAIT_RDY;
          end
          WAIT_RDY: if (data_rdy) begin
            // Fill with the tag latched at issue, not the slot's current address
            if (sel) begin
              line1  <= data_read;
              tag1   <= lat_tag[AW1-2:0];
              valid1 <= 1'b1;
            end else begin
              line0  <= data_read;
              tag0   <= lat_tag[AW0-2:0];
              valid0 <= 1'b1;
            end
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_jtframe_rom_2slot.sv
// Bench for jtframe_rom_2slot: vector table, directed corner sequences, and a
// randomized run against an SDRAM memory model with protocol/data invariants.
module tb_jtframe_rom_2slot;
  localparam logic [21:0] OFF0 = 22'h100;
  localparam logic [21:0] OFF1 = 22'h200;

  logic        clk_rom = 1'b0, rst_n = 1'b0;
  logic        slot0_cs = 1'b0, slot1_cs = 1'b0;
  logic [16:0] slot0_addr = '0, slot1_addr = '0;
  logic [15:0] slot0_dout, slot1_dout;
  logic        slot0_ok, slot1_ok;
  logic        sdram_req, refresh_en;
  logic [21:0] sdram_addr;
  logic        sdram_ack = 1'b0, data_rdy = 1'b0, loop_rst = 1'b0;
  logic [31:0] data_read = '0;

  logic        w_cs = 1'b0, w_zero = 1'b0;
  logic [16:0] w_addr = '0, w_zaddr = '0;
  logic [31:0] w_zdata = '0;
  logic [15:0] w_dout0, w_dout1;
  logic        w_ok0, w_ok1, w_req, w_ref;
  logic [21:0] w_sdaddr;

  jtframe_rom_2slot #(.AW0(17), .AW1(17), .OFFSET0(OFF0), .OFFSET1(OFF1)) u_dut (
    .clk_rom(clk_rom), .rst_n(rst_n),
    .slot0_cs(slot0_cs), .slot0_addr(slot0_addr), .slot0_dout(slot0_dout), .slot0_ok(slot0_ok),
    .slot1_cs(slot1_cs), .slot1_addr(slot1_addr), .slot1_dout(slot1_dout), .slot1_ok(slot1_ok),
    .sdram_req(sdram_req), .sdram_addr(sdram_addr), .sdram_ack(sdram_ack),
    .data_read(data_read), .data_rdy(data_rdy), .loop_rst(loop_rst), .refresh_en(refresh_en));

  jtframe_rom_2slot #(.AW0(17), .AW1(17), .OFFSET0(22'h3FFFFE), .OFFSET1(22'h0)) u_wrap (
    .clk_rom(clk_rom), .rst_n(rst_n),
    .slot0_cs(w_cs), .slot0_addr(w_addr), .slot0_dout(w_dout0), .slot0_ok(w_ok0),
    .slot1_cs(w_zero), .slot1_addr(w_zaddr), .slot1_dout(w_dout1), .slot1_ok(w_ok1),
    .sdram_req(w_req), .sdram_addr(w_sdaddr), .sdram_ack(w_zero),
    .data_read(w_zdata), .data_rdy(w_zero), .loop_rst(w_zero), .refresh_en(w_ref));

  always #5 clk_rom = ~clk_rom;

  int n_checks = 0, n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // SDRAM contents model: one 16-bit word per address
  function automatic logic [15:0] mem(input logic [21:0] w);
    return (w[15:0] * 16'd3) ^ {10'd0, w[21:16]} ^ 16'h1234;
  endfunction

  task automatic wait_req();
    int i = 0;
    while (!sdram_req && i < 40) begin
      @(negedge clk_rom);
      i++;
    end
    check("req_timeout", 32'(sdram_req), 32'd1);
  endtask

  task automatic pulse_ack();
    sdram_ack = 1'b1;
    @(negedge clk_rom);
    sdram_ack = 1'b0;
    check("req_low_after_ack", 32'(sdram_req), 32'd0);
  endtask

  task automatic pulse_rdy(input logic [31:0] d);
    data_read = d;
    data_rdy  = 1'b1;
    @(negedge clk_rom);
    data_rdy  = 1'b0;
  endtask

  task automatic serve(input logic [31:0] d, input int gap, output logic [21:0] a);
    wait_req();
    a = sdram_addr;
    pulse_ack();
    repeat (gap) @(negedge clk_rom);
    pulse_rdy(d);
  endtask

  typedef struct {
    bit          s;
    logic [16:0] addr;
    logic [31:0] d;
    bit          miss;
    logic [21:0] saddr;
    logic [15:0] dout;
  } vec_t;
  vec_t vt[7];

  logic [21:0] a, ca, p_addr;
  logic        p_req, p_ack;
  int          cph, cnt, st0, st1;

  initial begin
    vt[0] = '{0, 17'h00005, 32'hBEEF_CAFE, 1, 22'h104,   16'hBEEF};
    vt[1] = '{0, 17'h00004, 32'h0,         0, 22'h104,   16'hCAFE};
    vt[2] = '{1, 17'h00007, 32'h1111_2222, 1, 22'h206,   16'h1111};
    vt[3] = '{1, 17'h00006, 32'h0,         0, 22'h206,   16'h2222};
    vt[4] = '{0, 17'h1FFFF, 32'h3333_4444, 1, 22'h200FE, 16'h3333};
    vt[5] = '{0, 17'h00005, 32'hABCD_0123, 1, 22'h104,   16'hABCD};
    vt[6] = '{1, 17'h0000A, 32'h5555_6666, 1, 22'h20A,   16'h6666};

    // Reset
    repeat (2) @(negedge clk_rom);
    check("rst_req", 32'(sdram_req), 32'd0);
    check("rst_refresh", 32'(refresh_en), 32'd1);
    check("rst_ok0", 32'(slot0_ok), 32'd0);
    check("rst_dout0", 32'(slot0_dout), 32'd0);
    check("rst_wrap_req", 32'(w_req), 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk_rom);
    check("idle_req", 32'(sdram_req), 32'd0);
    check("idle_refresh", 32'(refresh_en), 32'd1);
    check("idle_ok1", 32'(slot1_ok), 32'd0);

    // Stray ack/rdy while idle must not fill the cache
    data_read = 32'h5555_AAAA; data_rdy = 1'b1; sdram_ack = 1'b1;
    @(negedge clk_rom);
    data_rdy = 1'b0; sdram_ack = 1'b0;
    check("stray_no_req", 32'(sdram_req), 32'd0);
    slot0_addr = 17'h0; slot0_cs = 1'b1;
    #1 check("stray_rdy_ignored", 32'(slot0_ok), 32'd0);
    serve(32'h2222_1111, 2, a);
    check("first_saddr", 32'(a), 32'(OFF0));
    check("first_dout", 32'(slot0_dout), 32'h1111);

    // Vector table: misses and zero-latency hits
    foreach (vt[i]) begin
      @(negedge clk_rom);
      slot0_cs = !vt[i].s;
      slot1_cs = vt[i].s;
      if (vt[i].s) slot1_addr = vt[i].addr; else slot0_addr = vt[i].addr;
      if (vt[i].miss) begin
        serve(vt[i].d, 3, a);
        check("vec_saddr", 32'(a), 32'(vt[i].saddr));
      end else begin
        #1 check("vec_hit_same_cycle", 32'(vt[i].s ? slot1_ok : slot0_ok), 32'd1);
        repeat (3) @(negedge clk_rom);
        check("vec_hit_no_req", 32'(sdram_req), 32'd0);
      end
      check("vec_ok", 32'(vt[i].s ? slot1_ok : slot0_ok), 32'd1);
      check("vec_dout", 32'(vt[i].s ? slot1_dout : slot0_dout), 32'(vt[i].dout));
      check("vec_addr_held", 32'(sdram_addr), 32'(vt[i].saddr));
    end

    // Simultaneous misses, slot 1 served last -> slot 0 first
    @(negedge clk_rom);
    slot0_cs = 1'b1; slot1_cs = 1'b1; slot0_addr = 17'h10; slot1_addr = 17'h10;
    serve(32'hA0A0_B0B0, 1, a); check("both_first_s0", 32'(a), 32'(OFF0 + 22'h10));
    serve(32'hC0C0_D0D0, 1, a); check("both_second_s1", 32'(a), 32'(OFF1 + 22'h10));
    check("both_ok0", 32'(slot0_ok), 32'd1);
    check("both_dout1", 32'(slot1_dout), 32'hD0D0);
    @(negedge clk_rom);
    slot0_addr = 17'h21; slot1_addr = 17'h21;
    serve(32'hE0E0_F0F0, 1, a); check("repeat_first_s0", 32'(a), 32'(OFF0 + 22'h20));
    serve(32'h1212_3434, 1, a); check("repeat_second_s1", 32'(a), 32'(OFF1 + 22'h20));
    check("repeat_dout0", 32'(slot0_dout), 32'hE0E0);
    // After a slot 0 win, slot 1 goes first
    @(negedge clk_rom);
    slot1_cs = 1'b0; slot0_addr = 17'h30;
    serve(32'h0, 1, a); check("solo_s0", 32'(a), 32'(OFF0 + 22'h30));
    @(negedge clk_rom);
    slot0_addr = 17'h40; slot1_cs = 1'b1; slot1_addr = 17'h30;
    serve(32'h0, 1, a); check("rr_after_s0_first_s1", 32'(a), 32'(OFF1 + 22'h30));
    serve(32'h0, 1, a); check("rr_after_s0_then_s0", 32'(a), 32'(OFF0 + 22'h40));

    // slot1 address changes while waiting for data
    @(negedge clk_rom);
    slot0_cs = 1'b0; slot1_addr = 17'h0;
    wait_req();
    check("chg_saddr", 32'(sdram_addr), 32'(OFF1));
    pulse_ack();
    slot1_addr = 17'h2;
    @(negedge clk_rom);
    pulse_rdy(32'h7777_8888);
    #1 check("chg_ok_low", 32'(slot1_ok), 32'd0);
    wait_req();
    check("chg_reissue_saddr", 32'(sdram_addr), 32'(OFF1 + 22'h2));
    slot1_addr = 17'h0;
    #1 check("chg_fill_tag0_ok", 32'(slot1_ok), 32'd1);
    check("chg_fill_tag0_dout", 32'(slot1_dout), 32'h8888);
    slot1_addr = 17'h2;
    pulse_ack();
    repeat (2) @(negedge clk_rom);
    pulse_rdy(32'h9999_AAAA);
    #1 check("chg_second_ok", 32'(slot1_ok), 32'd1);
    check("chg_second_dout", 32'(slot1_dout), 32'hAAAA);

    // loop_rst while waiting for ack
    @(negedge clk_rom);
    slot0_cs = 1'b1; slot0_addr = 17'h40; slot1_addr = 17'h50;
    #1 check("lr_pre_hit0", 32'(slot0_ok), 32'd1);
    wait_req();
    check("lr_saddr", 32'(sdram_addr), 32'(OFF1 + 22'h50));
    loop_rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_rom);
      check("lr_req_low", 32'(sdram_req), 32'd0);
      check("lr_ok0_low", 32'(slot0_ok), 32'd0);
      check("lr_ok1_low", 32'(slot1_ok), 32'd0);
    end
    loop_rst = 1'b0;
    serve(32'h0, 1, a); check("lr_reissue_s0", 32'(a), 32'(OFF0 + 22'h40));
    serve(32'h0, 1, a); check("lr_reissue_s1", 32'(a), 32'(OFF1 + 22'h50));
    check("lr_ok1_after", 32'(slot1_ok), 32'd1);

    // Address wrap on the second instance
    w_addr = 17'h4; w_cs = 1'b1;
    repeat (2) @(negedge clk_rom);
    check("wrap_req", 32'(w_req), 32'd1);
    check("wrap_saddr", 32'(w_sdaddr), 32'h000002);

    // Randomized run against the memory model
    slot0_cs = 1'b0; slot1_cs = 1'b0; loop_rst = 1'b1;
    @(negedge clk_rom);
    loop_rst = 1'b0;
    cph = 0; cnt = 0; st0 = 0; st1 = 0; ca = '0;
    p_req = sdram_req; p_ack = 1'b0; p_addr = sdram_addr;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk_rom);
      if (p_req && !sdram_req) check("rnd_req_drop_needs_ack", 32'(p_ack), 32'd1);
      if (p_req) check("rnd_addr_stable", 32'(sdram_addr), 32'(p_addr));
      sdram_ack = 1'b0;
      data_rdy  = 1'b0;
      if (cph == 0 && sdram_req) begin
        ca  = sdram_addr;
        cph = 1;
        cnt = int'($urandom_range(0, 2));
        check("rnd_req_addr_is_slot_line", 32'(
          (slot0_cs && ca == 22'(OFF0 + 22'({slot0_addr[16:1], 1'b0}))) ||
          (slot1_cs && ca == 22'(OFF1 + 22'({slot1_addr[16:1], 1'b0})))), 32'd1);
      end
      if (cph == 1) begin
        if (cnt == 0) begin
          sdram_ack = 1'b1;
          cph = 2;
          cnt = int'($urandom_range(0, 3));
        end else cnt--;
      end else if (cph == 2) begin
        if (cnt == 0) begin
          data_read = {mem(ca + 22'd1), mem(ca)};
          data_rdy  = 1'b1;
          cph = 0;
        end else cnt--;
      end
      if ($urandom_range(0, 15) == 0) begin
        slot0_cs = ($urandom_range(0, 3) != 0); slot0_addr = 17'($urandom_range(0, 7)); st0 = 0;
      end else st0++;
      if ($urandom_range(0, 15) == 0) begin
        slot1_cs = ($urandom_range(0, 3) != 0); slot1_addr = 17'($urandom_range(0, 7)); st1 = 0;
      end else st1++;
      #1;
      if (slot0_ok) check("rnd_dout0", 32'(slot0_dout), 32'(mem(22'(OFF0 + 22'(slot0_addr)))));
      if (slot1_ok) check("rnd_dout1", 32'(slot1_dout), 32'(mem(22'(OFF1 + 22'(slot1_addr)))));
      if (st0 == 30 && slot0_cs) check("rnd_live0", 32'(slot0_ok), 32'd1);
      if (st1 == 30 && slot1_cs) check("rnd_live1", 32'(slot1_ok), 32'd1);
      p_req  = sdram_req;
      p_ack  = sdram_ack;
      p_addr = sdram_addr;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
